// File: rtl/uart_reg_resp_pkg.sv
// ----------------------------------------------------------------------------
// uart_reg_resp_pkg
// Shared definitions for the UART register-access responder: FSM state
// encoding, frame sync bytes, command opcodes, response status codes and a
// saturating increment helper for the error counter.
// ----------------------------------------------------------------------------
package uart_reg_resp_pkg;

    // Request parsing runs HUNT..CHK, EXEC resolves the command, and the
    // R_* states stream the four response bytes out.
    typedef enum logic [3:0] {
        HUNT,
        CMD,
        ADDR,
        DATA,
        CHK,
        EXEC,
        R_SYNC,
        R_STAT,
        R_DATA,
        R_CHK
    } state_t;

    localparam logic [7:0] SYNC_REQ = 8'hA5;
    localparam logic [7:0] SYNC_RSP = 8'h5A;
    localparam logic [7:0] CMD_RD   = 8'h01;
    localparam logic [7:0] CMD_WR   = 8'h02;

    localparam logic [7:0] STAT_OK       = 8'h00;
    localparam logic [7:0] STAT_BAD_CHK  = 8'h01;
    localparam logic [7:0] STAT_BAD_CMD  = 8'h02;
    localparam logic [7:0] STAT_BAD_ADDR = 8'h03;

    // Counter increment that sticks at 0xFF instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_reg_resp_regfile.sv
// ----------------------------------------------------------------------------
// uart_reg_resp_regfile
// Bank of NUM_REGS 8-bit registers with one synchronous write port and one
// combinational read port. The whole bank is also exported flattened.
//
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears every reg)
//   we        - write enable; wdata lands in reg[waddr] at the next edge
//   waddr     - write address
//   wdata     - write data
//   raddr     - read address
//   rdata     - combinational read data (0x00 if raddr is outside the bank)
//   regs_q    - flattened bank, reg i at bits [8i+7:8i]
// ----------------------------------------------------------------------------
module uart_reg_resp_regfile
    import uart_reg_resp_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int AW       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [7:0]            wdata,
    input  logic [AW-1:0]         raddr,
    output logic [7:0]            rdata,
    output logic [8*NUM_REGS-1:0] regs_q
);

    logic [NUM_REGS-1:0][7:0] mem;

    // Address decode is done by comparison against each index so that a
    // non-power-of-two bank never writes past its last register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == AW'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Same decode style for the read side; unmatched addresses read zero.
    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == AW'(i)) begin
                rdata = mem[i];
            end
        end
    end

    assign regs_q = mem;

endmodule

// File: rtl/uart_reg_responder.sv
// ----------------------------------------------------------------------------
// uart_reg_responder
// Far-end register-access responder. Parses framed read/write requests from
// the UART receive stream, executes them against a local register bank and
// returns a 4-byte response (0x5A, STATUS, RDATA, RCHK) over a valid/ready
// transmit handshake.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   rx_valid   - one-cycle strobe per received byte
//   rx_data    - received byte
//   rx_error   - parity/framing error flag for the byte on rx_valid
//   tx_ready   - transmitter can accept a byte
//   tx_valid   - response byte available (registered)
//   tx_data    - response byte (registered, stable until transferred)
//   busy       - high whenever a frame or response is in progress
//   err_cnt    - saturating count of link/protocol errors
//   regs_q     - flattened register bank, reg i at bits [8i+7:8i]
// ----------------------------------------------------------------------------
module uart_reg_responder
    import uart_reg_resp_pkg::*;
#(
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  rx_error,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic [7:0]            err_cnt,
    output logic [8*NUM_REGS-1:0] regs_q
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    NUM_REGS_B = 8'(NUM_REGS);

    state_t        state;
    logic [7:0]    cmd_q;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic [7:0]    chk_acc;
    logic          chk_ok;
    logic [7:0]    status_q;
    logic [7:0]    rdata_q;
    logic [TW-1:0] to_cnt;

    logic          in_frame;
    logic          rx_err_hit;
    logic          timeout_hit;
    logic          exec_bad_chk;
    logic [7:0]    exec_status;
    logic [7:0]    exec_rdata;
    logic          rf_we;
    logic [7:0]    rf_rdata;

    assign in_frame = (state == CMD) || (state == ADDR) ||
                      (state == DATA) || (state == CHK);

    // Errored bytes only count while hunting or parsing; during EXEC and the
    // response they are dropped like any other byte.
    assign rx_err_hit = rx_valid && rx_error && (in_frame || (state == HUNT));

    // The counter holds TO_LAST in the final idle cycle; a byte arriving in
    // that same cycle takes precedence over the expiry.
    assign timeout_hit = in_frame && !rx_valid && (to_cnt == TO_LAST);

    assign exec_bad_chk = (state == EXEC) && !chk_ok;
    assign busy         = (state != HUNT);

    // Status priority: checksum, then opcode, then address range.
    always_comb begin
        exec_status = STAT_OK;
        if (!chk_ok) begin
            exec_status = STAT_BAD_CHK;
        end else if ((cmd_q != CMD_RD) && (cmd_q != CMD_WR)) begin
            exec_status = STAT_BAD_CMD;
        end else if (addr_q >= NUM_REGS_B) begin
            exec_status = STAT_BAD_ADDR;
        end
    end

    // Any error status forces RDATA to zero; a write echoes its data.
    always_comb begin
        exec_rdata = 8'h00;
        if (exec_status == STAT_OK) begin
            exec_rdata = (cmd_q == CMD_WR) ? data_q : rf_rdata;
        end
    end

    assign rf_we = (state == EXEC) && (exec_status == STAT_OK) && (cmd_q == CMD_WR);

    uart_reg_resp_regfile #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (addr_q[AW-1:0]),
        .wdata  (data_q),
        .raddr  (addr_q[AW-1:0]),
        .rdata  (rf_rdata),
        .regs_q (regs_q)
    );

    // Inter-byte timer: cleared by every received byte and whenever we are
    // not inside a request, so it only measures gaps within a frame.
    always_ff @(posedge clk) begin
        if (rst || !in_frame || rx_valid) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // All error sources in one cycle collapse into a single increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (rx_err_hit || timeout_hit || exec_bad_chk) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

    // Main FSM. The checksum accumulator starts from CMD and absorbs every
    // following payload byte; the CHK byte is compared against it and only
    // the pass/fail result is kept for EXEC. tx_valid/tx_data are loaded one
    // state ahead so each byte appears the cycle after the previous transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            chk_acc  <= 8'h00;
            chk_ok   <= 1'b0;
            status_q <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            case (state)
                HUNT: begin
                    if (rx_valid && !rx_error && (rx_data == SYNC_REQ)) begin
                        state <= CMD;
                    end
                end
                CMD, ADDR, DATA, CHK: begin
                    if (rx_valid && rx_error) begin
                        state <= HUNT;
                    end else if (rx_valid) begin
                        case (state)
                            CMD: begin
                                cmd_q   <= rx_data;
                                chk_acc <= rx_data;
                                state   <= ADDR;
                            end
                            ADDR: begin
                                addr_q  <= rx_data;
                                chk_acc <= chk_acc ^ rx_data;
                                state   <= (cmd_q == CMD_WR) ? DATA : CHK;
                            end
                            DATA: begin
                                data_q  <= rx_data;
                                chk_acc <= chk_acc ^ rx_data;
                                state   <= CHK;
                            end
                            default: begin
                                chk_ok <= (rx_data == chk_acc);
                                state  <= EXEC;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state <= HUNT;
                    end
                end
                EXEC: begin
                    status_q <= exec_status;
                    rdata_q  <= exec_rdata;
                    tx_valid <= 1'b1;
                    tx_data  <= SYNC_RSP;
                    state    <= R_SYNC;
                end
                R_SYNC: begin
                    if (tx_ready) begin
                        tx_data <= status_q;
                        state   <= R_STAT;
                    end
                end
                R_STAT: begin
                    if (tx_ready) begin
                        tx_data <= rdata_q;
                        state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (tx_ready) begin
                        tx_data <= status_q ^ rdata_q;
                        state   <= R_CHK;
                    end
                end
                R_CHK: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        state    <= HUNT;
                    end
                end
                default: begin
                    state    <= HUNT;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// ----------------------------------------------------------------------------
// tb_uart_reg_responder
// Self-checking bench for uart_reg_responder. Request frames come from a
// table of {request bytes, expected response, expected err_cnt, register
// probe} records; expected response bytes are pushed to a scoreboard queue
// as each frame is driven and a monitor pops them on every tx handshake.
// Hand-written sequences cover rx_error, backpressure, timeout, saturation
// and reset corner cases.
// ----------------------------------------------------------------------------
module tb_uart_reg_responder;

    localparam int NUM_REGS = 16;
    localparam int TO_CYC   = 40;

    logic                  clk;
    logic                  rst;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_error;
    logic                  tx_ready;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  busy;
    logic [7:0]            err_cnt;
    logic [8*NUM_REGS-1:0] regs_q;

    int vec_cnt    = 0;
    int miscompares = 0;
    logic [7:0] sb[$];

    typedef struct packed {
        logic [2:0]  n;
        logic [39:0] req;
        logic [31:0] rsp;
        logic [7:0]  exp_err;
        logic [3:0]  reg_idx;
        logic [7:0]  reg_val;
    } vec_t;

    vec_t tbl [9];

    uart_reg_responder #(
        .NUM_REGS       (NUM_REGS),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_error (rx_error),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .busy     (busy),
        .err_cnt  (err_cnt),
        .regs_q   (regs_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h, want %02h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: sampled a little after the falling edge so the
    // bench's own tx_ready update for this cycle is already visible.
    always @(negedge clk) begin
        #1;
        if (!rst && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                vec_cnt++;
                miscompares++;
                $display("[TB] FAIL unexpected_tx: got %02h, want no byte", tx_data);
            end else begin
                checkOutput("tx_byte", tx_data, sb.pop_front());
            end
        end
    end

    function automatic logic [7:0] reg_at(input int idx);
        return regs_q[8*idx +: 8];
    endfunction

    // Caller is at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_error = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic push_rsp(input logic [31:0] rsp);
        for (int k = 0; k < 4; k++) begin
            sb.push_back(rsp[31-8*k -: 8]);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy && sb.size() == 0) return;
            @(negedge clk);
        end
        vec_cnt++;
        miscompares++;
        $display("[TB] FAIL %s_idle: got busy=%0d pending=%0d, want idle", name, busy, sb.size());
    endtask

    task automatic applyStimulus(input vec_t v);
        push_rsp(v.rsp);
        for (int k = 0; k < int'(v.n); k++) begin
            send_byte(v.req[39-8*k -: 8], 1'b0);
        end
        wait_idle("frame");
        checkOutput("frame_err_cnt", err_cnt, v.exp_err);
        checkOutput("frame_reg", reg_at(int'(v.reg_idx)), v.reg_val);
    endtask

    logic [7:0] exp_err;

    initial begin
        tbl[0] = '{3'd5, 40'hA5_02_03_3C_3D, 32'h5A_00_3C_3C, 8'd0, 4'd3,  8'h3C};
        tbl[1] = '{3'd4, 40'hA5_01_03_02_00, 32'h5A_00_3C_3C, 8'd0, 4'd3,  8'h3C};
        tbl[2] = '{3'd5, 40'hA5_02_05_11_FF, 32'h5A_01_00_01, 8'd1, 4'd5,  8'h00};
        tbl[3] = '{3'd4, 40'hA5_01_10_11_00, 32'h5A_03_00_03, 8'd1, 4'd3,  8'h3C};
        tbl[4] = '{3'd4, 40'hA5_07_00_07_00, 32'h5A_02_00_02, 8'd1, 4'd0,  8'h00};
        tbl[5] = '{3'd5, 40'hA5_02_0F_99_94, 32'h5A_00_99_99, 8'd1, 4'd15, 8'h99};
        tbl[6] = '{3'd4, 40'hA5_01_0F_0E_00, 32'h5A_00_99_99, 8'd1, 4'd15, 8'h99};
        tbl[7] = '{3'd5, 40'hA5_02_10_55_47, 32'h5A_03_00_03, 8'd1, 4'd0,  8'h00};
        tbl[8] = '{3'd4, 40'hA5_07_00_00_00, 32'h5A_01_00_01, 8'd2, 4'd0,  8'h00};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_error = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("rst_err_cnt", err_cnt, 8'h00);
        checkOutput("rst_reg3", reg_at(3), 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i]);
        end
        exp_err = 8'd2;

        // rx_error mid-frame abandons it silently
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        exp_err++;
        checkOutput("rxerr_busy", {7'd0, busy}, 8'h00);
        checkOutput("rxerr_err_cnt", err_cnt, exp_err);
        // rx_error while hunting only counts
        send_byte(8'hA5, 1'b1);
        exp_err++;
        checkOutput("hunt_err_busy", {7'd0, busy}, 8'h00);
        checkOutput("hunt_err_cnt", err_cnt, exp_err);

        // Following write, checked cycle by cycle from the CHK byte
        push_rsp(32'h5A_00_42_42);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h47, 1'b0);
        for (int k = 0; k < 6; k++) begin
            checkOutput("wr_busy", {7'd0, busy}, (k < 5) ? 8'h01 : 8'h00);
            checkOutput("wr_tx_valid", {7'd0, tx_valid}, (k >= 1 && k <= 4) ? 8'h01 : 8'h00);
            checkOutput("wr_reg7", reg_at(7), (k == 0) ? 8'h00 : 8'h42);
            @(negedge clk);
        end
        wait_idle("wr");
        checkOutput("wr_err_cnt", err_cnt, exp_err);

        // Backpressure on a read response; rx bytes during it are dropped
        tx_ready = 1'b0;
        push_rsp(32'h5A_00_3C_3C);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h02, 1'b0);
        checkOutput("bp_exec_tx_valid", {7'd0, tx_valid}, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            checkOutput("bp_tx_valid", {7'd0, tx_valid}, 8'h01);
            checkOutput("bp_tx_data", tx_data, 8'h5A);
            rx_valid = (i == 5) || (i == 8);
            rx_data  = 8'hA5;
            rx_error = (i == 8);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_error = 1'b0;
        checkOutput("bp_err_cnt", err_cnt, exp_err);
        tx_ready = 1'b1;
        wait_idle("bp");

        // Timeout with no further bytes
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (TO_CYC - 1) @(negedge clk);
        checkOutput("to_busy_before", {7'd0, busy}, 8'h01);
        @(negedge clk);
        exp_err++;
        checkOutput("to_busy_after", {7'd0, busy}, 8'h00);
        checkOutput("to_err_cnt", err_cnt, exp_err);

        // Byte landing exactly on the expiry cycle keeps the frame alive
        push_rsp(32'h5A_00_3C_3C);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (TO_CYC - 1) @(negedge clk);
        send_byte(8'h03, 1'b0);
        checkOutput("to_edge_busy", {7'd0, busy}, 8'h01);
        send_byte(8'h02, 1'b0);
        wait_idle("to_edge");
        checkOutput("to_edge_err_cnt", err_cnt, exp_err);

        // Saturation of err_cnt
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h00, 1'b1);
        end
        checkOutput("sat_err_cnt", err_cnt, 8'hFF);

        // Reset in the middle of a stalled response: nothing is resent
        tx_ready = 1'b0;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h02, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("mid_rsp_busy", {7'd0, busy}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        checkOutput("mid_rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("mid_rst_err_cnt", err_cnt, 8'h00);
        checkOutput("mid_rst_reg3", reg_at(3), 8'h00);
        tx_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        checkOutput("sb_drained", 8'(sb.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Far-end register-access responder for the UART link. It consumes the received byte stream (valid/data/error) and parses framed read/write commands against a local register bank. It returns one framed response per accepted command through the transmitter's valid/ready handshake. It sits between a UART receiver/transmitter pair and the device registers it exposes.

## Interface
- NUM_REGS, 16, number of 8-bit registers; legal range 1..128.
- TIMEOUT_CYCLES, 1024, idle cycles allowed between bytes inside a frame before the frame is abandoned; must be ≥2.
- clk  in  1  sole clock; all inputs synchronous to it.
- rst  in  1  **synchronous, active-high reset**.
- rx_valid  in  1  one-cycle pulse per received byte.
- rx_data  in  8  received byte; qualified by rx_valid.
- rx_error  in  1  parity/framing error on the byte presented with rx_valid.
- tx_ready  in  1  transmitter can accept a byte.
- tx_valid  out  1  response byte available.
- tx_data  out  8  response byte.
- busy  out  1  high whenever the FSM is not in HUNT.
- err_cnt  out  8  saturating error counter.
- regs_q  out  8*NUM_REGS  register bank contents, flattened; reg i occupies bits [8i+7:8i].

## Operation
- Request frame:
  - SYNC 0xA5, CMD, ADDR, then DATA for writes only, then CHK.
  - CHK = XOR of CMD, ADDR and (if present) DATA.
  - CMD values: 0x01 = read, 0x02 = write. Any other value is "bad command" and is parsed with read length (no DATA byte).
- Response frame: always 4 bytes: 0x5A, STATUS, RDATA, RCHK.
  - RCHK = STATUS ^ RDATA.
  - RDATA is the read value for a read, the written value for a write, and 0x00 on any error status.
- STATUS codes, evaluated in this priority:
  - 0x01: bad checksum.
  - 0x02: bad command.
  - 0x03: ADDR ≥ NUM_REGS.
  - 0x00: OK.
- A write commits only when STATUS is 0x00.
- FSM states: HUNT, CMD, ADDR, DATA, CHK, EXEC, R_SYNC, R_STAT, R_DATA, R_CHK.
  - HUNT → CMD on an rx_valid byte of 0xA5; any other byte is ignored.
  - CMD → ADDR → (DATA if write) → CHK → EXEC, each on an rx_valid byte.
  - EXEC lasts one cycle: status is computed, the write is committed, RDATA is latched.
  - EXEC → R_SYNC → R_STAT → R_DATA → R_CHK, each transition on a tx handshake.
  - After the last handshake (in R_CHK) → HUNT.
- rx_error with rx_valid:
  - In any state CMD..CHK: abandon the frame, go to HUNT, increment err_cnt, send no response.
  - In HUNT: increment err_cnt only.
- Inter-byte timeout:
  - A counter reloads on every rx_valid and runs in states CMD..CHK.
  - On reaching TIMEOUT_CYCLES with no byte: go to HUNT, increment err_cnt, send no response.
  - If rx_valid arrives in the expiry cycle, the byte wins and is processed normally.
- A bad-checksum frame increments err_cnt, in addition to producing its response.
- rx bytes arriving in EXEC or the R_* states are dropped silently; err_cnt is unchanged.
- err_cnt saturates at 0xFF. Multiple error sources in one cycle increment it by 1.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, busy=0, err_cnt=0, all registers 0x00, state HUNT.
- Reset mid-frame or mid-response: the frame or response is discarded; nothing is retransmitted.
- CHK byte accepted at cycle N:
  - EXEC occupies N+1.
  - The written register is visible on regs_q at N+2.
  - tx_valid rises at N+2 with tx_data=0x5A.
- Handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - tx_valid and tx_data hold stable until that transfer.
  - The next byte is presented the cycle after the transfer.
  - tx_valid never depends combinationally on tx_ready.
- Minimum response duration is 4 cycles (tx_ready constantly high). busy drops the cycle after the R_CHK handshake.
- A request's SYNC byte is accepted no earlier than the cycle busy is low.

## Structure
- Package uart_reg_resp_pkg holds:
  - the state enum;
  - constants SYNC_REQ=0xA5, SYNC_RSP=0x5A, CMD_RD=0x01, CMD_WR=0x02;
  - the status codes.
- Sub-module uart_reg_resp_regfile holds the register bank.
  - Ports: clk, rst, we, waddr, wdata, raddr, rdata (combinational read), regs_q.
  - Writes are synchronous.
- The parent owns the FSM, timeout counter, checksum accumulator and err_cnt.

## Test plan
- Write: send A5 02 03 3C 3D → response 5A 00 3C 3C; regs_q reg3=0x3C; err_cnt=0.
- Read-back: after the write above, send A5 01 03 02 → response 5A 00 3C 3C.
- Error statuses:
  - Send A5 02 05 11 FF → response 5A 01 00 01; reg5 stays 0x00; err_cnt=1.
  - Send A5 01 10 11 → response 5A 03 00 03.
  - Send A5 07 00 07 → response 5A 02 00 02.
- rx_error mid-frame: send A5 02, then a byte with rx_error=1 → no tx_valid; err_cnt increments; a following valid write frame succeeds.
- Backpressure: hold tx_ready low 20 cycles during a read response → tx_valid=1 and tx_data=0x5A stay stable throughout; all 4 bytes follow in order once tx_ready rises.
- Timeout: send A5 01, then idle TIMEOUT_CYCLES cycles → busy falls; no response; err_cnt increments. Repeat with the 3rd byte landing exactly on the expiry cycle → the frame continues normally.
